axis_rr_arbiter: RTL and testbench

Packet-level round-robin arbiter sharing one AXI-Stream output between S_COUNT input streams. It sits upstream of axis_fifo and multiplexes several producers into one datapath. Grants are held for a whole packet, so packets are never interleaved. The output is registered through a 2-entry skid buffer, giving full throughput inside a packet.

---
 rtl/axis_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter merging S_COUNT AXI-Stream inputs onto one output via a 2-entry skid stage.
// Optional AXIS_ARB_TID_EN adds m_axis_tid, the source stream index of each output beat.
module axis_rr_arbiter #(
  parameter int unsigned S_COUNT     = 4,
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned LAST_ENABLE = 1,
  localparam int unsigned IDX_W      = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
`ifdef AXIS_ARB_TID_EN
  output logic [IDX_W-1:0]              m_axis_tid,
`endif
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state;
  logic [IDX_W-1:0]      last_grant;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_last;
  logic                  skid_valid;
`ifdef AXIS_ARB_TID_EN
  logic [IDX_W-1:0]      skid_tid;
`endif

  logic                  any_req;
  logic [IDX_W-1:0]      pick;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  accept;
  logic                  beat_last;
  logic                  drain;
  logic                  skid_full_next;
  logic                  busy_next;
  logic [IDX_W-1:0]      next_grant;
  logic [S_COUNT-1:0]    ready_next;

  // First requester scanning upward from the stream after the previous winner
  always_comb begin : rr_pick
    int unsigned cand;
    cand    = 0;
    any_req = 1'b0;
    pick    = '0;
    for (int unsigned i = 1; i <= S_COUNT; i++) begin
      cand = 32'(last_grant) + i;
      if (cand >= S_COUNT) cand = cand - S_COUNT;
      if (!any_req && s_axis_tvalid[IDX_W'(cand)]) begin
        any_req = 1'b1;
        pick    = IDX_W'(cand);
      end
    end
  end

  // Granted-stream mux, skid occupancy and next-cycle ready; ready is registered so it
  // reflects the skid state the upstream beat would land in.
  always_comb begin
    in_data   = s_axis_tdata[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    in_valid  = s_axis_tvalid[grant_idx];
    in_last   = s_axis_tlast[grant_idx];
    accept    = (state == BUSY) && in_valid && s_axis_tready[grant_idx];
    beat_last = (LAST_ENABLE != 0) ? in_last : 1'b1;
    drain     = !m_axis_tvalid || m_axis_tready;
    skid_full_next = drain ? 1'b0 : (skid_valid || accept);
    if (state == IDLE) begin
      busy_next  = any_req;
      next_grant = pick;
    end else begin
      busy_next  = !(accept && beat_last);
      next_grant = grant_idx;
    end
    ready_next = '0;
    if (busy_next && !skid_full_next) ready_next[next_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_valid   <= 1'b0;
      grant_idx     <= '0;
      last_grant    <= IDX_W'(S_COUNT - 1);
      s_axis_tready <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      skid_valid    <= 1'b0;
      skid_last     <= 1'b0;
      skid_data     <= '0;
`ifdef AXIS_ARB_TID_EN
      m_axis_tid    <= '0;
      skid_tid      <= '0;
`endif
    end else begin
      s_axis_tready <= ready_next;

      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= BUSY;
            grant_valid <= 1'b1;
            grant_idx   <= pick;
            last_grant  <= pick;
          end
        end
        BUSY: begin
          if (accept && beat_last) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end
        end
      endcase

      // Main register refills from skid first so beat order is kept
      if (drain) begin
        if (skid_valid) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= skid_data;
          m_axis_tlast  <= skid_last;
`ifdef AXIS_ARB_TID_EN
          m_axis_tid    <= skid_tid;
`endif
          skid_valid    <= 1'b0;
        end else begin
          m_axis_tvalid <= accept;
          if (accept) begin
            m_axis_tdata <= in_data;
            m_axis_tlast <= beat_last;
`ifdef AXIS_ARB_TID_EN
            m_axis_tid   <= grant_idx;
`endif
          end
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        skid_last  <= beat_last;
`ifdef AXIS_ARB_TID_EN
        skid_tid   <= grant_idx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: directed packets, per-stream expected queues, decoupled output monitor.
module tb_axis_rr_arbiter;

  localparam int unsigned S  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;

  typedef struct {
    int          gap;
    logic        last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [S*DW-1:0] s_axis_tdata;
  logic [S-1:0]    s_axis_tvalid;
  logic [S-1:0]    s_axis_tready;
  logic [S-1:0]    s_axis_tlast;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;
`ifdef AXIS_ARB_TID_EN
  logic [IW-1:0]   m_axis_tid;
`endif

  beat_t drv_q[S][$];
  exp_t  exp_q[S][$];
  int    grant_log[$];
  int    acc_cyc[$];
  bit    acc_last[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    bp_mode = 1'b0;

  axis_rr_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .LAST_ENABLE(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
`ifdef AXIS_ARB_TID_EN
    .m_axis_tid    (m_axis_tid),
`endif
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Beat b of a packet carries {stream, base+b}; gap_len<0 gives random 0..2 idle cycles per beat
  function automatic void send(input int s, input int base, input int len, input int gap_beat, input int gap_len);
    beat_t bt;
    exp_t  ex;
    for (int b = 0; b < len; b++) begin
      bt.data = {4'(s), 28'(base + b)};
      bt.last = (b == len - 1);
      if (gap_len < 0) bt.gap = int'($urandom_range(0, 2));
      else bt.gap = (b == gap_beat) ? gap_len : 0;
      ex.data = bt.data;
      ex.last = bt.last;
      exp_q[s].push_back(ex);
      drv_q[s].push_back(bt);
    end
  endfunction

  function automatic bit pending();
    bit p;
    p = m_axis_tvalid;
    for (int g = 0; g < S; g++) p = p | (drv_q[g].size() != 0) | (exp_q[g].size() != 0);
    return p;
  endfunction

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (n < budget && pending()) begin
      @(negedge clk);
      n++;
    end
    if (pending()) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d cycles expected=drained", n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_grants(input string name, input int exp_list[$]);
    check({name, "_count"}, 32'(grant_log.size()), 32'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < grant_log.size(); i++)
      check(name, 32'(grant_log[i]), 32'(exp_list[i]));
  endtask

  // Source driver: beats are popped once seen accepted at the preceding edge
  initial begin : driver
    logic [S-1:0] acc;
    bit           cur[S];
    int           gap_left[S];
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    for (int g = 0; g < S; g++) begin
      cur[g] = 1'b0;
      gap_left[g] = 0;
    end
    forever begin
      @(negedge clk);
      acc = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int g = 0; g < S; g++) begin
        if (acc[g] && drv_q[g].size() > 0) begin
          void'(drv_q[g].pop_front());
          cur[g] = 1'b0;
        end
        if (drv_q[g].size() == 0) cur[g] = 1'b0;
        else if (!cur[g]) begin
          cur[g] = 1'b1;
          gap_left[g] = drv_q[g][0].gap;
        end
        if (cur[g] && gap_left[g] == 0) begin
          s_axis_tvalid[g] = 1'b1;
          s_axis_tdata[g*DW +: DW] = drv_q[g][0].data;
          s_axis_tlast[g] = drv_q[g][0].last;
        end else begin
          s_axis_tvalid[g] = 1'b0;
          if (cur[g]) gap_left[g]--;
        end
      end
    end
  end

  // Output monitor: scoreboard compare, interleave check, grant and input-accept logging
  initial begin : monitor
    bit           in_pkt;
    bit           prev_gv;
    int           cur_sid;
    int           sid;
    logic [S-1:0] sacc;
    exp_t         e;
    in_pkt = 1'b0;
    prev_gv = 1'b0;
    cur_sid = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_pkt = 1'b0;
        prev_gv = 1'b0;
      end else begin
        sacc = s_axis_tvalid & s_axis_tready;
        if (sacc != '0) begin
          acc_cyc.push_back(cyc);
          acc_last.push_back(|(sacc & s_axis_tlast));
        end
        if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_idx));
        prev_gv = grant_valid;
        if (m_axis_tvalid && m_axis_tready) begin
          sid = int'(m_axis_tdata[31:28]);
          if (sid >= S || exp_q[sid].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=0x%0h expected=no beat", m_axis_tdata);
          end else begin
            e = exp_q[sid].pop_front();
            check("beat_data", m_axis_tdata, e.data);
            check("beat_last", 32'(m_axis_tlast), 32'(e.last));
`ifdef AXIS_ARB_TID_EN
            check("beat_tid", 32'(m_axis_tid), 32'(sid));
`endif
          end
          if (in_pkt) check("no_interleave", 32'(sid), 32'(cur_sid));
          in_pkt = !m_axis_tlast;
          cur_sid = sid;
        end
      end
    end
  end

  initial begin : main
    int n;
    int p;
    int len;
    int sl[3];
    int exp_l[$];
    sl = '{0, 1, 3};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_m_tdata", m_axis_tdata, 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_idx", 32'(grant_idx), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin with every stream requesting: 2-beat packets
    grant_log.delete();
    acc_cyc.delete();
    acc_last.delete();
    send(0, 'h10, 2, 0, 0);
    send(1, 'h10, 2, 0, 0);
    send(2, 'h10, 2, 0, 0);
    send(3, 'h10, 2, 0, 0);
    send(0, 'h20, 2, 0, 0);
    send(1, 'h20, 2, 0, 0);
    wait_drain(2000);
    exp_l = '{0, 1, 2, 3, 0, 1};
    check_grants("rr_grant", exp_l);
    check("rr_accepts", 32'(acc_cyc.size()), 32'd12);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("rr_input_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), acc_last[i-1] ? 32'd2 : 32'd1);

    // Single stream 2 packet A0..A3 with cycle-accurate latency
    send(2, 'hA0, 4, 0, 0);
    n = 0;
    while (n < 50 && !(s_axis_tvalid[2] && s_axis_tready[2])) begin
      @(negedge clk);
      n++;
    end
    check("t1_first_accept_seen", 32'(s_axis_tvalid[2] && s_axis_tready[2]), 32'd1);
    check("t1_grant_valid", 32'(grant_valid), 32'd1);
    check("t1_grant_idx", 32'(grant_idx), 32'd2);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t1_m_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("t1_m_tdata", m_axis_tdata, 32'h2000_00A0 + 32'(k - 1));
      if (k == 3) check("t1_grant_held", 32'(grant_valid), 32'd1);
      if (k == 4) begin
        check("t1_grant_drop", 32'(grant_valid), 32'd0);
        check("t1_m_tlast", 32'(m_axis_tlast), 32'd1);
      end
    end
    wait_drain(200);

    // Held grant: stream 1 stalls 5 cycles mid-packet while stream 3 requests
    grant_log.delete();
    send(1, 'h40, 4, 2, 5);
    n = 0;
    while (n < 50 && !(grant_valid && grant_idx == 2'd1)) begin
      @(negedge clk);
      n++;
    end
    check("hold_grant1_seen", 32'(grant_valid && grant_idx == 2'd1), 32'd1);
    send(3, 'h40, 2, 0, 0);
    repeat (4) @(negedge clk);
    check("hold_grant_idx_mid", 32'(grant_idx), 32'd1);
    wait_drain(500);
    exp_l = '{1, 3};
    check_grants("hold_grant", exp_l);

    // Back-pressure: ~1024 beats over streams 0,1,3 with random ready and valid gaps
    bp_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      p = 0;
      while (n < 342) begin
        len = int'($urandom_range(1, 8));
        send(sl[k], 'h1000 + p * 16, len, 0, -1);
        n += len;
        p++;
      end
    end
    wait_drain(30000);
    bp_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during beat 3 of an 8-beat packet
    send(2, 'h300, 8, 0, 0);
    n = 0;
    while (n < 50 && !(s_axis_tvalid[2] && s_axis_tready[2] && s_axis_tdata[2*DW +: 16] == 16'h0302)) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_beat3_seen", 32'(s_axis_tvalid[2] && s_axis_tready[2]), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int g = 0; g < S; g++) begin
      drv_q[g].delete();
      exp_q[g].delete();
    end
    #1;
    check("rst_mid_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_mid_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_mid_grant_valid", 32'(grant_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    grant_log.delete();
    for (int g = 0; g < S; g++) send(g, 'h500, 1, 0, 0);
    wait_drain(500);
    exp_l = '{0, 1, 2, 3};
    check_grants("post_rst_grant", exp_l);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
